maxpool_2x2_stream: RTL and testbench
=====================================

Name: maxpool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pool for the six conv1 feature maps.
- Sits directly downstream of the post-MAC bias/ReLU/shift stage when the MAC layer select is conv1.
- Consumes one 6-channel 16-bit pixel per handshake in raster order (24x24 per frame).
- Emits one 6-channel pooled pixel per 2x2 window (12x12 per frame) to the conv2 feature buffer writer.

Parameters:
- DATA_W, 16, width of each channel sample (signed two's complement).
- IN_W, 24, input feature-map width; must be even.
- IN_H, 24, input feature-map height; must be even.
- CH, 6, channel count; fixed by the port list, used only for internal arrays.

Ports:
- clk  in  1  Single system clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- frame_start  in  1  Synchronous one-cycle clear of the frame position and partial state.
- in_valid  in  1  Input pixel present.
- in_ready  out  1  Block can accept a pixel this cycle.
- in_0..in_5  in  DATA_W each  Channel samples (signed) from the bias/ReLU stage.
- out_valid  out  1  Pooled pixel held in the output register.
- out_ready  in  1  Consumer accepts the pooled pixel.
- out_0..out_5  out  DATA_W each  Pooled channel maxima.
- out_row  out  $clog2(IN_H/2)  Pooled row index, 0..11.
- out_col  out  $clog2(IN_W/2)  Pooled column index, 0..11.
- frame_done  out  1  One-cycle pulse when the last pooled pixel of a frame is handed off.

Behaviour:
- Reset: all outputs 0; out_valid=0; frame_done=0; col/row counters 0; horizontal hold registers and line buffer 0.
- Accept: an input is accepted when in_valid && in_ready.
  - in_ready = !frame_start && !(out_valid && !out_ready). The output register is never overwritten.
- Counters: col counts 0..IN_W-1 and row counts 0..IN_H-1, advancing only on accept.
  - At col=IN_W-1, col wraps to 0 and row increments.
  - At the last pixel (row=IN_H-1, col=IN_W-1), both wrap to 0. The next frame starts without frame_start.
- Even col accepted: store the 6 samples in the hold registers.
- Odd col accepted: compute hmax[c] = signed max(hold[c], in_c).
  - Even row: write hmax into line buffer entry col>>1 (IN_W/2 entries x CH x DATA_W, registers).
  - Odd row: out_c <= signed max(linebuf[col>>1][c], hmax[c]); out_row <= row>>1; out_col <= col>>1; out_valid <= 1.
- Latency: out_valid rises on the cycle after the accepting edge of the bottom-right pixel of each window.
- Output hold: out_valid clears on out_valid && out_ready unless a new result loads in the same cycle. That case is legal: in_ready is high when out_ready is high. Data stays stable while out_valid && !out_ready.
- frame_done: asserted for exactly the cycle of the handoff (out_valid && out_ready) with out_row=IN_H/2-1 and out_col=IN_W/2-1.
- Comparison: full-width signed. Ties select either operand; the value is identical. No saturation or shift; the output width equals the input width.
- frame_start: has priority over any input that cycle (in_ready=0, nothing accepted).
  - Clears col, row, hold registers and out_valid. A pending unconsumed output is discarded.
  - The line buffer need not be cleared; every entry is rewritten before it is read.
- reset mid-frame: asynchronous return to reset state; a partial frame is lost.
- Odd IN_W or IN_H is illegal; flag it with an elaboration-time assertion.

Decomposition:
- Shared package cnn_pkg holds DATA_W=16, CONV1_CH=6, CONV1_OUT_W=24, CONV1_OUT_H=24, POOL1_W=12, POOL1_H=12, and a typedef of a signed DATA_W sample.
- Package includes a typedef of a CH-element sample vector used by both this block and the upstream stage.
- One sub-module: smax2, a combinational signed max of two DATA_W operands. It is instantiated CH times for the horizontal max and CH times for the vertical max.

Test Plan:
- Full frame, out_ready tied 1, in_valid continuous, ch0 pixel(r,c)=r*24+c:
  - 144 outputs; output (i,j) ch0 = (2i+1)*24+2j+1.
  - out_row/out_col raster 0..11; frame_done high exactly once, with output (11,11).
- Window with ch0 values 5, -3 / 7, 2 (top-left, top-right, bottom-left, bottom-right); ch1 all -8:
  - out_0=7, out_1=-8 (0xFFF8). Confirms signed compare.
- Backpressure: hold out_ready=0 for 5 cycles after first out_valid:
  - in_ready=0 throughout, out_* stable. On release, one handoff occurs and streaming resumes with no lost or duplicated window.
- Bubbles: randomly deassert in_valid (50%):
  - Results match the scenario-1 values; counters advance only on accept.
- frame_start asserted with in_valid=1 after 30 accepted pixels, with a pending output:
  - in_ready=0 that cycle, out_valid clears. The following 576 pixels yield a correct 12x12 frame starting at (0,0).
- Assert reset asynchronously mid-row 7:
  - All outputs 0 immediately. The next full frame is correct and frame_done pulses once.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared CNN datapath constants and sample types.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

   localparam int DATA_W      = 16;
   localparam int CONV1_CH    = 6;
   localparam int CONV1_OUT_W = 24;
   localparam int CONV1_OUT_H = 24;
   localparam int POOL1_W     = 12;
   localparam int POOL1_H     = 12;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef sample_t [CONV1_CH-1:0]   sample_vec_t;

endpackage
`default_nettype wire

// File: rtl/smax2.sv
`default_nettype none
// ============================================================================
// Module   : smax2
// Brief    : Combinational signed maximum of two samples.
// Revision : 1.0
// ============================================================================
module smax2
   import cnn_pkg::*;
#(
   parameter int W = DATA_W
)(
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_max
);

   assign o_max = (i_a > i_b) ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_2x2_stream
// Brief    : Streaming 2x2 stride-2 signed max-pool over six conv1 channels.
// Revision : 1.0
// ============================================================================
module maxpool_2x2_stream #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IN_W   = cnn_pkg::CONV1_OUT_W,
   parameter int IN_H   = cnn_pkg::CONV1_OUT_H,
   parameter int CH     = cnn_pkg::CONV1_CH
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_start,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_0,
   input  logic [DATA_W-1:0]           in_1,
   input  logic [DATA_W-1:0]           in_2,
   input  logic [DATA_W-1:0]           in_3,
   input  logic [DATA_W-1:0]           in_4,
   input  logic [DATA_W-1:0]           in_5,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_0,
   output logic [DATA_W-1:0]           out_1,
   output logic [DATA_W-1:0]           out_2,
   output logic [DATA_W-1:0]           out_3,
   output logic [DATA_W-1:0]           out_4,
   output logic [DATA_W-1:0]           out_5,
   output logic [$clog2(IN_H/2)-1:0]   out_row,
   output logic [$clog2(IN_W/2)-1:0]   out_col,
   output logic                        frame_done
);

   localparam int COL_W = $clog2(IN_W);
   localparam int ROW_W = $clog2(IN_H);
   localparam int PC_W  = $clog2(IN_W/2);
   localparam int PR_W  = $clog2(IN_H/2);
   localparam int LB_N  = IN_W/2;

   generate
      if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_bad_dims
         $error("maxpool_2x2_stream: IN_W and IN_H must be even");
      end
   endgenerate

   logic [COL_W-1:0]         r_col;
   logic [ROW_W-1:0]         r_row;
   logic signed [DATA_W-1:0] r_hold [CH];
   logic signed [DATA_W-1:0] r_lb   [LB_N][CH];
   logic signed [DATA_W-1:0] r_out  [CH];
   logic                     r_out_valid;
   logic [PR_W-1:0]          r_out_row;
   logic [PC_W-1:0]          r_out_col;

   logic signed [DATA_W-1:0] w_in   [CH];
   logic signed [DATA_W-1:0] w_lbrd [CH];
   logic signed [DATA_W-1:0] w_hmax [CH];
   logic signed [DATA_W-1:0] w_vmax [CH];
   logic [PC_W-1:0]          w_pcol;
   logic [PR_W-1:0]          w_prow;
   logic                     w_accept;
   logic                     w_col_last;
   logic                     w_row_last;

   assign w_in[0] = in_0;
   assign w_in[1] = in_1;
   assign w_in[2] = in_2;
   assign w_in[3] = in_3;
   assign w_in[4] = in_4;
   assign w_in[5] = in_5;

   assign w_pcol     = PC_W'(r_col >> 1);
   assign w_prow     = PR_W'(r_row >> 1);
   assign w_col_last = (r_col == COL_W'(IN_W-1));
   assign w_row_last = (r_row == ROW_W'(IN_H-1));

   // A held result blocks input so the output register is never overwritten.
   assign in_ready = !frame_start && !(r_out_valid && !out_ready);
   assign w_accept = in_valid && in_ready;

   generate
      for (genvar g = 0; g < CH; g++) begin : g_ch
         assign w_lbrd[g] = r_lb[w_pcol][g];

         smax2 #(.W(DATA_W)) u_hmax (
            .i_a   (r_hold[g]),
            .i_b   (w_in[g]),
            .o_max (w_hmax[g])
         );

         smax2 #(.W(DATA_W)) u_vmax (
            .i_a   (w_lbrd[g]),
            .i_b   (w_hmax[g]),
            .o_max (w_vmax[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col       <= '0;
         r_row       <= '0;
         r_out_valid <= 1'b0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         for (int c = 0; c < CH; c++) begin
            r_hold[c] <= '0;
            r_out[c]  <= '0;
         end
         for (int e = 0; e < LB_N; e++) begin
            for (int c = 0; c < CH; c++) begin
               r_lb[e][c] <= '0;
            end
         end
      end else if (frame_start) begin
         // Line buffer is left alone: each entry is rewritten on an even row before use.
         r_col       <= '0;
         r_row       <= '0;
         r_out_valid <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            r_hold[c] <= '0;
         end
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end

            if (!r_col[0]) begin
               for (int c = 0; c < CH; c++) begin
                  r_hold[c] <= w_in[c];
               end
            end else if (!r_row[0]) begin
               for (int c = 0; c < CH; c++) begin
                  r_lb[w_pcol][c] <= w_hmax[c];
               end
            end else begin
               for (int c = 0; c < CH; c++) begin
                  r_out[c] <= w_vmax[c];
               end
               r_out_row   <= w_prow;
               r_out_col   <= w_pcol;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;
   assign out_0     = r_out[0];
   assign out_1     = r_out[1];
   assign out_2     = r_out[2];
   assign out_3     = r_out[3];
   assign out_4     = r_out[4];
   assign out_5     = r_out[5];

   assign frame_done = r_out_valid && out_ready &&
                       (r_out_row == PR_W'(IN_H/2-1)) &&
                       (r_out_col == PC_W'(IN_W/2-1));

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_2x2_stream
// Brief    : Self-checking bench for maxpool_2x2_stream (directed vectors).
// Revision : 1.0
// ============================================================================
module tb_maxpool_2x2_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_d  [6];
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_d [6];
   logic [3:0]  out_row;
   logic [3:0]  out_col;
   logic        frame_done;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0][15:0] ch0;
      logic [3:0][15:0] ch1;
      logic [15:0]      e0;
      logic [15:0]      e1;
   } win_vec_t;

   win_vec_t    tbl [12];
   logic [95:0] q_data [$];
   logic [7:0]  q_rc   [$];
   int          fd_cnt = 0;
   logic [7:0]  fd_rc  = '0;

   maxpool_2x2_stream dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_0        (in_d[0]),
      .in_1        (in_d[1]),
      .in_2        (in_d[2]),
      .in_3        (in_d[3]),
      .in_4        (in_d[4]),
      .in_5        (in_d[5]),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_0       (out_d[0]),
      .out_1       (out_d[1]),
      .out_2       (out_d[2]),
      .out_3       (out_d[3]),
      .out_4       (out_d[4]),
      .out_5       (out_d[5]),
      .out_row     (out_row),
      .out_col     (out_col),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // Handoffs are recorded mid-cycle; they complete on the following rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q_data.push_back({out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]});
         q_rc.push_back({out_row, out_col});
      end
      if (frame_done) begin
         fd_cnt++;
         fd_rc = {out_row, out_col};
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic win_vec_t mk(input int a0, b0, c0, d0, a1, b1, c1, d1, x0, x1);
      win_vec_t w;
      w.ch0[0] = 16'(a0); w.ch0[1] = 16'(b0); w.ch0[2] = 16'(c0); w.ch0[3] = 16'(d0);
      w.ch1[0] = 16'(a1); w.ch1[1] = 16'(b1); w.ch1[2] = 16'(c1); w.ch1[3] = 16'(d1);
      w.e0 = 16'(x0);
      w.e1 = 16'(x1);
      return w;
   endfunction

   function automatic logic [15:0] pixval(input int r, input int c, input int k, input int mode);
      int v;
      int p;
      if (mode == 1 && r < 2 && k < 2) begin
         p = r*2 + c%2;
         return (k == 0) ? tbl[c/2].ch0[p] : tbl[c/2].ch1[p];
      end
      v = r*24 + c + k;
      return (k%2 == 0) ? 16'(v) : 16'(-v);
   endfunction

   function automatic logic [15:0] exp_out(input int i, input int j, input int k, input int mode);
      int best;
      logic signed [15:0] t;
      best = -100000;
      for (int dr = 0; dr < 2; dr++) begin
         for (int dc = 0; dc < 2; dc++) begin
            t = pixval(2*i+dr, 2*j+dc, k, mode);
            if (int'(t) > best) best = int'(t);
         end
      end
      return 16'(best);
   endfunction

   function automatic logic [95:0] exp_pix(input int i, input int j, input int mode);
      logic [95:0] e;
      for (int k = 0; k < 6; k++) e[k*16 +: 16] = exp_out(i, j, k, mode);
      return e;
   endfunction

   task automatic put_pixel(input int r, input int c, input int mode, input bit bubble);
      int n;
      if (bubble && $urandom_range(0, 1) == 1) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) in_d[k] = pixval(r, c, k, mode);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout r=%0d c=%0d got=in_ready_low exp=accept", r, c);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int mode, input bit bubble, input int count);
      for (int p = 0; p < count; p++) put_pixel(p/24, p%24, mode, bubble);
   endtask

   task automatic clear_log();
      q_data.delete();
      q_rc.delete();
      fd_cnt = 0;
      fd_rc  = '0;
   endtask

   task automatic verify_frame(input int mode, input string tag);
      chk({tag, "_count"}, 128'(q_data.size()), 128'd144);
      for (int n = 0; n < 144 && n < q_data.size(); n++) begin
         chk($sformatf("%s_rc%0d", tag, n), 128'(q_rc[n]), 128'({4'(n/12), 4'(n%12)}));
         chk($sformatf("%s_data%0d", tag, n), 128'(q_data[n]), 128'(exp_pix(n/12, n%12, mode)));
      end
      chk({tag, "_frame_done_cnt"}, 128'(fd_cnt), 128'd1);
      chk({tag, "_frame_done_rc"}, 128'(fd_rc), 128'h bb);
      clear_log();
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [95:0] snap;
      int          n;

      tbl[0]  = mk(5, -3, 7, 2,                 -8, -8, -8, -8,              7, -8);
      tbl[1]  = mk(-1, -2, -3, -4,               0, 0, 0, 0,                 -1, 0);
      tbl[2]  = mk(-32768, -32768, -32768, -32767, 32767, -32768, 0, 1,     -32767, 32767);
      tbl[3]  = mk(100, 200, 300, 400,           -1, -100, -1000, -2,        400, -1);
      tbl[4]  = mk(400, 300, 200, 100,           5, 5, 5, 5,                 400, 5);
      tbl[5]  = mk(-5, 10, -20, 3,               -32768, -1, -32768, -32768, 10, -1);
      tbl[6]  = mk(0, -1, 0, -1,                 1, 2, 3, 4,                 0, 4);
      tbl[7]  = mk(32767, -32768, 0, 0,          -7, -6, -5, -9,             32767, -5);
      tbl[8]  = mk(-100, -50, -25, -75,          9, -9, 9, -9,               -25, 9);
      tbl[9]  = mk(1, 1, 1, 1,                   -3, 3, -3, 3,               1, 3);
      tbl[10] = mk(-2, -200, -20, -2000,         50, 60, 70, 80,             -2, 80);
      tbl[11] = mk(7, 8, 9, -10,                 -1234, -123, -12, -1,       9, -1);

      reset       = 1'b0;
      frame_start = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      for (int k = 0; k < 6; k++) in_d[k] = '0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_frame_done", 128'(frame_done), 128'd0);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_data", 128'({out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]}), 128'd0);
      chk("reset_rc", 128'({out_row, out_col}), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_log();

      // Full frame, continuous streaming
      send_frame(0, 1'b0, 576);
      drain();
      verify_frame(0, "full");

      // Hand-computed signed windows along pooled row 0
      send_frame(1, 1'b0, 576);
      drain();
      for (int j = 0; j < 12; j++) begin
         if (j < q_data.size()) begin
            chk($sformatf("tbl%0d_ch0", j), 128'(q_data[j][15:0]), 128'(tbl[j].e0));
            chk($sformatf("tbl%0d_ch1", j), 128'(q_data[j][31:16]), 128'(tbl[j].e1));
         end
      end
      verify_frame(1, "table");

      // Input bubbles
      send_frame(0, 1'b1, 576);
      drain();
      verify_frame(0, "bubble");

      // Output backpressure on the first result
      fork
         send_frame(0, 1'b0, 576);
         begin
            n = 0;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!out_valid && n < 100);
            chk("bp_first_valid", 128'(out_valid), 128'd1);
            out_ready = 1'b0;
            snap = {out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]};
            chk("bp_first_data", 128'(snap), 128'(exp_pix(0, 0, 0)));
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready", 128'(in_ready), 128'd0);
               chk("bp_out_valid", 128'(out_valid), 128'd1);
               chk("bp_stable", 128'({out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]}), 128'(snap));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      verify_frame(0, "bp");

      // frame_start discards a pending result and restarts the frame
      send_frame(0, 1'b0, 29);
      out_ready = 1'b0;
      put_pixel(1, 5, 0, 1'b0);
      frame_start = 1'b1;
      in_valid    = 1'b1;
      for (int k = 0; k < 6; k++) in_d[k] = pixval(1, 6, k, 0);
      @(negedge clk);
      chk("fs_in_ready", 128'(in_ready), 128'd0);
      chk("fs_pending", 128'(out_valid), 128'd1);
      @(posedge clk); #1;
      frame_start = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      chk("fs_out_valid_cleared", 128'(out_valid), 128'd0);
      clear_log();
      @(posedge clk); #1;
      send_frame(0, 1'b0, 576);
      drain();
      verify_frame(0, "fs");

      // Asynchronous reset in the middle of row 7
      send_frame(0, 1'b0, 7*24 + 11);
      #2 reset = 1'b1;
      #1;
      chk("areset_out_valid", 128'(out_valid), 128'd0);
      chk("areset_data", 128'({out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]}), 128'd0);
      chk("areset_rc", 128'({out_row, out_col}), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_log();
      send_frame(0, 1'b0, 576);
      drain();
      verify_frame(0, "areset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
